// File: rtl/ahf_mem_arb_v.sv
// ahf_mem_arb_v: round-robin block-burst arbiter and sequencer for the shared main memory
module ahf_mem_arb_v #(
  parameter int AW     = 10,
  parameter int DW     = 14,
  parameter int WB     = 4,
  parameter int RD_LAT = 1
) (
  input  logic             Clk,
  input  logic             Resetn,
  input  logic             ic_req,
  input  logic [AW-WB-1:0] ic_blk,
  input  logic             dc_req,
  input  logic             dc_we,
  input  logic [AW-WB-1:0] dc_blk,
  input  logic [DW-1:0]    dc_wdata,
  input  logic [DW-1:0]    mem_rdata,
  output logic             ic_gnt,
  output logic             dc_gnt,
  output logic             rd_valid,
  output logic [WB-1:0]    rd_word,
  output logic [DW-1:0]    rd_data,
  output logic [WB-1:0]    xfer_word,
  output logic             ic_done,
  output logic             dc_done,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_wren,
  output logic [DW-1:0]    mem_wdata
);
  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, last_q, last_d, rw_q, rw_d;
  logic [AW-WB-1:0] blk_q, blk_d;
  logic [WB-1:0] cnt_q, cnt_d;
  logic [RD_LAT-1:0] pv_q, pv_d;
  logic [WB-1:0] pw_q [RD_LAT];
  logic [WB-1:0] pw_d [RD_LAT];
  logic pick_dc, done;
  // owner encoding: 0 = IC, 1 = DC; on contention the side that did not go last wins
  always_comb begin
    pick_dc = dc_req && (!ic_req || !last_q);
    done = (state_q == XFER) ? (rw_q && &cnt_q)
         : (state_q == DRAIN) && pv_q[RD_LAT-1] && &pw_q[RD_LAT-1];
    state_d = state_q;
    owner_d = owner_q;
    blk_d = blk_q;
    rw_d = rw_q;
    cnt_d = cnt_q;
    last_d = done ? owner_q : last_q;
    case (state_q)
      IDLE: if (ic_req || dc_req) begin
        state_d = XFER;
        owner_d = pick_dc;
        blk_d = pick_dc ? dc_blk : ic_blk;
        rw_d = pick_dc && dc_we;
        cnt_d = '0;
      end
      XFER: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = rw_q ? IDLE : DRAIN;
      end
      DRAIN: if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    pv_d[0] = (state_q == XFER) && !rw_q;
    pw_d[0] = cnt_q;
    for (int i = 1; i < RD_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pw_d[i] = pw_q[i-1];
    end
  end
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q <= 1'b1;
      rw_q <= 1'b0;
      blk_q <= '0;
      cnt_q <= '0;
      pv_q <= '0;
      pw_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q <= last_d;
      rw_q <= rw_d;
      blk_q <= blk_d;
      cnt_q <= cnt_d;
      pv_q <= pv_d;
      pw_q <= pw_d;
    end
  end
  always_comb begin
    ic_gnt = (state_q != IDLE) && !owner_q;
    dc_gnt = (state_q != IDLE) && owner_q;
    rd_valid = pv_q[RD_LAT-1];
    rd_word = rd_valid ? pw_q[RD_LAT-1] : '0;
    rd_data = rd_valid ? mem_rdata : '0;
    xfer_word = cnt_q;
    ic_done = done && !owner_q;
    dc_done = done && owner_q;
    mem_addr = (state_q == XFER) ? {blk_q, cnt_q} : '0;
    mem_wren = (state_q == XFER) && rw_q;
    mem_wdata = mem_wren ? dc_wdata : '0;
  end
endmodule
